// File: rtl/pds_apb_master.sv
// pds_apb_master: APB requester for the PDS register space.
// Accepts one read/write command at a time on a valid/ready port, runs the
// APB SETUP/ACCESS sequence, and returns read data or status on a
// valid/ready response port. A wait-state timeout and an alignment check
// keep a silent or misaddressed slave from hanging the command port.
//
// Ports:
//   pclk, prst                         clock, async active-high reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write, cmd_addr, cmd_wdata     command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata, rsp_err                 response payload
//   paddr, pwdata, pwrite, psel,       APB requester outputs
//   penable
//   prdata, pready                     APB completer inputs
module pds_apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic misaligned_c;
    logic timeout_c;

    assign misaligned_c = (cmd_addr[1:0] != 2'b00);
    assign timeout_c    = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (cmd_valid) state_d = misaligned_c ? RESP : SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: if (pready || timeout_c) state_d = RESP;
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the wait-state counter
    always_comb begin
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (misaligned_c) begin
                        // Rejected without touching the bus; paddr keeps its old value
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        pwdata_d  = cmd_write ? cmd_wdata : '0;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // pready takes priority over a timeout in the same cycle
                if (pready || timeout_c) begin
                    cnt_d       = '0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~pready;
                    rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // cmd_ready is a pure decode of the state register
    assign cmd_ready = (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_pds_apb_master.sv
// tb_pds_apb_master: directed bench for pds_apb_master with a small PDS
// register-slave model (4 words, word 2 resets to 0xFF) that supports a
// programmable number of wait states or a permanent stall.
module tb_pds_apb_master;

    logic        pclk = 1'b0;
    logic        prst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave model controls
    logic        stall = 1'b0;
    int          wait_states = 0;
    int          acc_cnt = 0;
    logic [31:0] mem [4];

    pds_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    assign pready = psel && penable && !stall && (acc_cnt >= wait_states);
    assign prdata = mem[paddr[3:2]];

    always @(posedge pclk) begin
        if (psel && penable) begin
            if (pready) begin
                acc_cnt <= 0;
                if (pwrite) mem[paddr[3:2]] <= pwdata;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One command end to end; latency counted in cycles from the accept edge
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int psel_cyc, output int pen_cyc, output logic [31:0] pwd_seen);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        psel_cyc = 0;
        pen_cyc = 0;
        pwd_seen = 32'h0;
        while (!rsp_valid && lat < 60) begin
            if (psel) begin
                psel_cyc++;
                pwd_seen = pwdata;
            end
            if (penable) pen_cyc++;
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'h1);
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd, pwd;
    logic        err;
    int          lat, pc, ec;

    initial begin
        mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0000_00FF; mem[3] = 32'h0;
        prst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        tick(); tick();
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        prst = 1'b0;
        tick();

        // Zero-wait read of the 0xFF register
        do_cmd(1'b0, 32'h8, 32'h0, rd, err, lat, pc, ec, pwd);
        check("rd8_data", rd, 32'h0000_00FF);
        check("rd8_err", 32'(err), 32'h0);
        check("rd8_lat", 32'(lat), 32'd3);
        check("rd8_psel_cyc", 32'(pc), 32'd2);
        check("rd8_pen_cyc", 32'(ec), 32'd1);
        check("rd8_pwdata", pwd, 32'h0);
        check("idle_psel", 32'(psel), 32'h0);

        // Write then read back
        do_cmd(1'b1, 32'h4, 32'h0000_A5A5, rd, err, lat, pc, ec, pwd);
        check("wr4_err", 32'(err), 32'h0);
        check("wr4_rdata", rd, 32'h0);
        check("wr4_pwdata", pwd, 32'h0000_A5A5);
        check("wr4_mem", mem[1], 32'h0000_A5A5);
        check("idle_paddr_hold", paddr, 32'h4);
        do_cmd(1'b0, 32'h4, 32'h0, rd, err, lat, pc, ec, pwd);
        check("rd4_data", rd, 32'h0000_A5A5);
        check("rd4_err", 32'(err), 32'h0);

        // Two wait states add two cycles
        wait_states = 2;
        do_cmd(1'b0, 32'h8, 32'h0, rd, err, lat, pc, ec, pwd);
        check("ws2_lat", 32'(lat), 32'd5);
        check("ws2_data", rd, 32'h0000_00FF);

        // pready arrives in the timeout cycle: no error
        wait_states = 15;
        do_cmd(1'b0, 32'h8, 32'h0, rd, err, lat, pc, ec, pwd);
        check("edge_err", 32'(err), 32'h0);
        check("edge_pen_cyc", 32'(ec), 32'd16);
        check("edge_data", rd, 32'h0000_00FF);
        wait_states = 0;

        // Stalled slave times out after 16 ACCESS cycles
        stall = 1'b1;
        do_cmd(1'b0, 32'h0, 32'h0, rd, err, lat, pc, ec, pwd);
        check("to_err", 32'(err), 32'h1);
        check("to_rdata", rd, 32'h0);
        check("to_pen_cyc", 32'(ec), 32'd16);
        check("to_lat", 32'(lat), 32'd18);
        stall = 1'b0;

        // Misaligned address rejected immediately, no bus activity
        do_cmd(1'b0, 32'h6, 32'h0, rd, err, lat, pc, ec, pwd);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(err), 32'h1);
        check("mis_rdata", rd, 32'h0);
        check("mis_psel_cyc", 32'(pc), 32'd0);

        // Response back-pressure: response stable, new command ignored
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = '0;
        tick();
        cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'hDEAD_BEEF;
        tick(); tick();
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("bp_rdata", rsp_rdata, 32'h0000_00FF);
            check("bp_err", 32'(rsp_err), 32'h0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            check("bp_psel", 32'(psel), 32'h0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_released", 32'(rsp_valid), 32'h0);
        tick(); tick(); tick();
        check("bp_no_write", mem[3], 32'h0);

        // Reset in the middle of ACCESS
        stall = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("pre_rst_penable", 32'(penable), 32'h1);
        prst = 1'b1;
        #1;
        check("mid_rst_psel", 32'(psel), 32'h0);
        check("mid_rst_penable", 32'(penable), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        prst = 1'b0;
        stall = 1'b0;
        tick();
        do_cmd(1'b0, 32'h8, 32'h0, rd, err, lat, pc, ec, pwd);
        check("post_rst_data", rd, 32'h0000_00FF);
        check("post_rst_err", 32'(err), 32'h0);
        check("post_rst_lat", 32'(lat), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
